// File: rtl/fetch_assembler.sv
// Byte-serial instruction fetch: reads four ROM bytes over a two-phase
// trigger/ready handshake and presents the little-endian word downstream.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | fetch paused (en low or just reset), no request outstanding
// REQ     | one cycle: drive addrOut, toggle triggerOut, load wait counter
// WAIT    | count down; leave once the count expires and ROM reports ready
// CAPTURE | write dataIn into lane byte_idx; next byte or complete the word
// HOLD    | instr_valid high until downstream accepts
module fetch_assembler #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] addrOut,
    output logic        triggerOut,
    input  logic [7:0]  dataIn,
    input  logic        readyIn,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_CAPTURE,
        S_HOLD
    } state_t;

    localparam logic [31:0] PC_INIT   = RESET_PC & 32'hFFFF_FFFC;
    localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] addr_q, addr_d;
    logic        trig_q, trig_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ipc_q, ipc_d;
    logic        valid_q, valid_d;
    logic        rdy_s1_q, rdy_s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pc_q     <= PC_INIT;
            idx_q    <= 2'd0;
            addr_q   <= PC_INIT;
            trig_q   <= 1'b0;
            cnt_q    <= 4'd0;
            instr_q  <= 32'd0;
            ipc_q    <= 32'd0;
            valid_q  <= 1'b0;
            rdy_s1_q <= 1'b0;
            rdy_s2_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            idx_q    <= idx_d;
            addr_q   <= addr_d;
            trig_q   <= trig_d;
            cnt_q    <= cnt_d;
            instr_q  <= instr_d;
            ipc_q    <= ipc_d;
            valid_q  <= valid_d;
            rdy_s1_q <= readyIn;
            rdy_s2_q <= rdy_s1_q;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        trig_d  = trig_q;
        cnt_d   = cnt_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        valid_d = valid_q;

        case (state_q)
            S_IDLE: begin
                if (en) state_d = S_REQ;
            end
            S_REQ: begin
                addr_d  = pc_q + {30'd0, idx_q};
                trig_d  = ~trig_q;
                cnt_d   = WAIT_LOAD;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // The count expires on the cycle it would reach zero, so WAIT
                // lasts exactly WAIT_CYCLES cycles when the ROM is already ready.
                if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
                if ((cnt_q <= 4'd1) && rdy_s2_q) state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                case (idx_q)
                    2'd0:    instr_d[7:0]   = dataIn;
                    2'd1:    instr_d[15:8]  = dataIn;
                    2'd2:    instr_d[23:16] = dataIn;
                    default: instr_d[31:24] = dataIn;
                endcase
                if (idx_q == 2'd3) begin
                    idx_d   = 2'd0;
                    ipc_d   = pc_q;
                    pc_d    = pc_q + 32'd4;
                    valid_d = 1'b1;
                    state_d = S_HOLD;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = en ? S_REQ : S_IDLE;
                end
            end
            S_HOLD: begin
                if (instr_ready) begin
                    valid_d = 1'b0;
                    state_d = en ? S_REQ : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Redirect wins over everything except a handshake already taking
        // place this cycle; pc only ever advances in CAPTURE, so it is simply
        // replaced here. A trigger toggle from REQ still goes out.
        if (redirect_valid) begin
            pc_d    = redirect_pc & 32'hFFFF_FFFC;
            idx_d   = 2'd0;
            valid_d = 1'b0;
            instr_d = instr_q;
            ipc_d   = ipc_q;
            state_d = en ? S_REQ : S_IDLE;
        end
    end

    assign addrOut     = addr_q;
    assign triggerOut  = trig_q;
    assign instr       = instr_q;
    assign instr_pc    = ipc_q;
    assign instr_valid = valid_q;
    assign busy        = (state_q != S_IDLE) && (state_q != S_HOLD);

endmodule

// File: tb/tb_fetch_assembler.sv
// Scoreboard bench for fetch_assembler: an address-level ROM/word-stream model
// feeds an expected queue that a separate monitor drains on each handshake.
module tb_fetch_assembler;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] addrOut;
    logic        triggerOut;
    logic [7:0]  dataIn;
    logic        readyIn;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        busy;

    fetch_assembler #(.RESET_PC(32'h0000_0000), .WAIT_CYCLES(W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en             (en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .addrOut        (addrOut),
        .triggerOut     (triggerOut),
        .dataIn         (dataIn),
        .readyIn        (readyIn),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] next_pc;
    logic [31:0] addr_log[$];
    int          tog_cyc[$];
    logic [31:0] got_words[$];
    logic [31:0] got_pcs[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc_n   = 0;
    int          valid_rise_cyc = -1;

    function automatic logic [7:0] rom_byte(input logic [31:0] a);
        case (a)
            32'd0:   return 8'h78;
            32'd1:   return 8'h56;
            32'd2:   return 8'h34;
            32'd3:   return 8'h12;
            32'd4:   return 8'hEF;
            32'd5:   return 8'hBE;
            32'd6:   return 8'hAD;
            32'd7:   return 8'hDE;
            default: return a[7:0] ^ (a[15:8] * 8'd3) ^ a[31:24] ^ 8'h5A;
        endcase
    endfunction

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return {rom_byte(a + 32'd3), rom_byte(a + 32'd2), rom_byte(a + 32'd1), rom_byte(a)};
    endfunction

    // ROM: data follows the held request address.
    assign dataIn = rom_byte(addrOut);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic top_up();
        exp_t e;
        while (exp_q.size() < 4) begin
            e.word = rom_word(next_pc);
            e.pc   = next_pc;
            exp_q.push_back(e);
            next_pc = next_pc + 32'd4;
        end
    endtask

    task automatic reset_model();
        exp_q.delete();
        next_pc = 32'h0000_0000;
        top_up();
    endtask

    // A word being handed over in this very cycle is still delivered.
    task automatic do_redirect(input logic [31:0] p);
        exp_t head;
        if (instr_valid && instr_ready && exp_q.size() > 0) begin
            head = exp_q[0];
            exp_q.delete();
            exp_q.push_back(head);
        end else begin
            exp_q.delete();
        end
        next_pc = p & 32'hFFFF_FFFC;
        top_up();
        redirect_pc    = p;
        redirect_valid = 1'b1;
    endtask

    task automatic step();
        @(negedge clk);
        redirect_valid = 1'b0;
    endtask

    task automatic wait_words(input int n, input string nm);
        int c = 0;
        while (got_pcs.size() < n && c < 400) begin step(); c++; end
        if (got_pcs.size() < n) chk(nm, 32'(got_pcs.size()), 32'(n));
    endtask

    task automatic wait_toggles(input int n, input string nm);
        int c = 0;
        while (addr_log.size() < n && c < 400) begin step(); c++; end
        if (addr_log.size() < n) chk(nm, 32'(addr_log.size()), 32'(n));
    endtask

    task automatic wait_byte(input logic [1:0] b, input string nm);
        int c = 0;
        logic [31:0] last;
        logic hit = 1'b0;
        while (!hit && c < 400) begin
            step(); c++;
            if (addr_log.size() > 0) begin
                last = addr_log[addr_log.size() - 1];
                hit  = (last[1:0] == b);
            end
        end
        if (!hit) chk(nm, 32'd0, 32'd1);
    endtask

    always @(posedge clk) cyc_n <= cyc_n + 1;

    initial begin
        forever begin
            @(triggerOut);
            #1;
            if (rst_n) begin
                addr_log.push_back(addrOut);
                tog_cyc.push_back(cyc_n);
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n) begin
                if (instr_valid && valid_rise_cyc < 0) valid_rise_cyc = cyc_n;
                if (instr_valid && instr_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("scoreboard_empty", instr_pc, 32'hXXXX_XXXX);
                    end else begin
                        e = exp_q.pop_front();
                        chk("instr", instr, e.word);
                        chk("instr_pc", instr_pc, e.pc);
                        top_up();
                    end
                    got_words.push_back(instr);
                    got_pcs.push_back(instr_pc);
                end
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: run did not finish, %0d checks so far", n_tests);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k, k2, nw, ns, c;
        rst_n = 1'b0; en = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
        readyIn = 1'b1; instr_ready = 1'b1;
        reset_model();

        #12;
        chk("rst_addrOut", addrOut, 32'h0);
        chk("rst_trigger", {31'd0, triggerOut}, 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) step();
        chk("no_req_while_en_low", 32'(addr_log.size()), 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // Two words from the fixed ROM image, ready always high.
        en = 1'b1;
        wait_words(2, "first_words_timeout");
        if (got_words.size() >= 2) begin
            chk("word0", got_words[0], 32'h1234_5678);
            chk("word0_pc", got_pcs[0], 32'h0);
            chk("word1", got_words[1], 32'hDEAD_BEEF);
            chk("word1_pc", got_pcs[1], 32'h4);
        end
        if (addr_log.size() >= 8) begin
            for (int i = 0; i < 8; i++) chk("byte_addr", addr_log[i], 32'(i));
            // REQ occupies the cycle before the edge on which trigger toggles.
            chk("latency", 32'(valid_rise_cyc - tog_cyc[0]), 32'(4 * (W + 2) - 1));
        end else begin
            chk("byte_addr_count", 32'(addr_log.size()), 32'd8);
        end

        // Downstream stall.
        instr_ready = 1'b0;
        c = 0;
        while (!instr_valid && c < 200) begin step(); c++; end
        chk("stall_valid_rise", {31'd0, instr_valid}, 32'd1);
        k = addr_log.size();
        repeat (20) begin
            step();
            chk("stall_valid", {31'd0, instr_valid}, 32'd1);
            chk("stall_instr", instr, exp_q[0].word);
            chk("stall_instr_pc", instr_pc, exp_q[0].pc);
        end
        chk("stall_no_toggle", 32'(addr_log.size()), 32'(k));
        instr_ready = 1'b1;

        // Redirect while byte 2 is in flight.
        wait_byte(2'd2, "byte2_timeout");
        nw = got_pcs.size();
        k  = addr_log.size();
        do_redirect(32'h0000_0103);
        step();
        wait_toggles(k + 1, "redirect_req_timeout");
        if (addr_log.size() > k) chk("redirect_addr", addr_log[k], 32'h100);
        wait_words(nw + 1, "redirect_word_timeout");
        if (got_pcs.size() > nw) chk("redirect_pc_delivered", got_pcs[nw], 32'h100);

        // ROM not ready for a long time.
        readyIn = 1'b0;
        k = addr_log.size();
        wait_toggles(k + 1, "romstall_req_timeout");
        k2 = addr_log.size();
        nw = got_pcs.size();
        repeat (50) begin
            step();
            chk("romstall_busy", {31'd0, busy}, 32'd1);
        end
        chk("romstall_no_toggle", 32'(addr_log.size()), 32'(k2));
        chk("romstall_no_word", 32'(got_pcs.size()), 32'(nw));
        readyIn = 1'b1;
        wait_toggles(k2 + 1, "romstall_resume_timeout");

        // Reset pulse during byte 1.
        wait_byte(2'd1, "byte1_timeout");
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_addrOut", addrOut, 32'h0);
        chk("mid_rst_trigger", {31'd0, triggerOut}, 32'd0);
        chk("mid_rst_instr", instr, 32'h0);
        chk("mid_rst_instr_pc", instr_pc, 32'h0);
        chk("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        reset_model();
        nw = got_pcs.size();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_words(nw + 1, "post_rst_word_timeout");
        if (got_pcs.size() > nw) begin
            chk("post_rst_pc", got_pcs[nw], 32'h0);
            chk("post_rst_word", got_words[nw], 32'h1234_5678);
        end

        // Top-of-memory wrap, started from IDLE so the next REQ is the redirect.
        en = 1'b0;
        c = 0;
        do begin step(); c++; end while ((busy || instr_valid) && c < 200);
        chk("drain_idle", {31'd0, busy | instr_valid}, 32'd0);
        en = 1'b1;
        k  = addr_log.size();
        nw = got_pcs.size();
        do_redirect(32'hFFFF_FFFC);
        step();
        wait_toggles(k + 5, "wrap_toggle_timeout");
        if (addr_log.size() >= k + 5) begin
            chk("wrap_first_addr", addr_log[k], 32'hFFFF_FFFC);
            chk("wrap_next_addr", addr_log[k + 4], 32'h0);
        end
        wait_words(nw + 1, "wrap_word_timeout");
        if (got_pcs.size() > nw) chk("wrap_instr_pc", got_pcs[nw], 32'hFFFF_FFFC);

        // Random traffic.
        ns = got_pcs.size();
        for (int i = 0; i < 800; i++) begin
            step();
            en          = ($urandom_range(0, 7) != 0);
            instr_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 9) == 0) readyIn = ~readyIn;
            if ($urandom_range(0, 39) == 0)
                do_redirect(($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + ($urandom & 32'hF)) : $urandom);
        end
        step();
        en = 1'b1; instr_ready = 1'b1; readyIn = 1'b1;
        repeat (80) step();
        chk("random_progress", {31'd0, got_pcs.size() > ns + 10}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
